decade_down_counter: RTL
========================

# decade_down_counter

Cascadable multi-digit BCD down-counter, the counting-down counterpart of the team's decade up-counter. It holds DIGITS decimal digits and loads a preset value. It decrements once per enabled cycle, with decimal borrow ripple between digits. It flags when the count reaches zero and when it wraps. Typical uses are countdown timers and reload-style dividers, where the up-counter cannot serve.

## Interface
Parameters:
- DIGITS, default 2: number of BCD digits; legal range 1..8.
- STOP_AT_ZERO, default 0: 0 = wrap from all-zero to all-nines; 1 = saturate at zero.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: reset, synchronous, active-high.
- en, input, 1: decrement enable, sampled each rising edge.
- load, input, 1: load request; has priority over en.
- load_val, input, 4*DIGITS: preset value, packed BCD, digit 0 in bits [3:0].
- count, output, 4*DIGITS: current count, packed BCD, registered.
- zero, output, 1: registered; high exactly when count is all-zero.
- borrow, output, 1: registered one-cycle pulse, high in the cycle a wrap from zero to all-nines becomes visible on count.
- load_err, output, 1: registered one-cycle pulse, high when a load was rejected.

## Operation
- Reset (rst=1 at an edge) forces: count=0, zero=1, borrow=0, load_err=0. Reset overrides load and en.
- Priority per edge: rst > load > en > hold.
- Load, valid case: if load=1 and every digit of load_val is 0..9, count takes load_val. zero is updated to match load_val. borrow=0 and load_err=0.
- Load, invalid case: if any load_val digit is 10..15, count and zero hold, load_err=1 for one cycle and borrow=0. en is ignored in that cycle because load still has priority.
- Decrement (load=0, en=1):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and passes a borrow to the next digit.
  - A digit above 0 decrements and stops the ripple.
- Count all-zero with en=1 and STOP_AT_ZERO=0: count becomes all-nines (for example 99 for DIGITS=2), borrow=1, zero=0.
- Count all-zero with en=1 and STOP_AT_ZERO=1: count holds at zero, borrow=0, zero stays 1.
- Hold (load=0, en=0): count and zero hold; borrow and load_err return to 0.
- borrow and load_err are never high together. Each is high for exactly one cycle per triggering event.
- Digits always stay in 0..9. No illegal BCD state is reachable from reset.
- Cascading: another instance's en may be driven by this block's borrow. The downstream instance then decrements one cycle after the wrap.

## Timing
- All outputs are registered and change only on rising edges of clk.
- Load latency: 1 cycle. load_val sampled at edge N appears on count after edge N.
- Decrement latency: 1 cycle per enabled edge. Back-to-back en gives one decrement per cycle with no bubbles.
- zero is coincident with count: same edge, no extra lag.
- borrow is coincident with the all-nines value on count.
- Borrow ripple across all DIGITS resolves within one cycle; there is no multi-cycle ripple.
- Reset asserted mid-count takes effect at the next edge, regardless of load or en.
- After rst deasserts, the first load or en acts on the following edge.

## Test plan
- Reset and hold: assert rst for 2 cycles with en=1 and load=1, then release with en=0. Required: count=00, zero=1, borrow=0, load_err=0 throughout.
- Load and count down, DIGITS=2: load 12, then en=1 for 3 cycles. Required: count 12, 11, 10, 09. zero=0 throughout; borrow from the tens digit ripples correctly at 10 to 09.
- Wrap, STOP_AT_ZERO=0: load 01, then en=1 for 3 cycles. Required: count 00 with zero=1, then 99 with borrow=1 and zero=0 in the same cycle, then 98 with borrow=0.
- Saturate, STOP_AT_ZERO=1: load 00, then en=1 for 4 cycles. Required: count stays 00, zero=1, borrow never asserted.
- Invalid load and priority: with count=57, apply load_val=0x3A, load=1 and en=1 together. Required: count stays 57, load_err=1 for one cycle. Next, load 40 with en=1 in the same cycle. Required: count=40, with no decrement in that cycle.
- Cascade and mid-count reset: chain two instances, with the upper instance's en driven by the lower instance's borrow. Count the lower instance through 00 to 99. Required: the upper instance decrements one cycle after the borrow. Then assert rst while counting. Required: both instances read 00 at the next edge.

Source files
------------

// File: rtl/decade_down_counter.sv
// Multi-digit BCD down-counter with preset load, zero flag and wrap borrow; 1-cycle latency on load/decrement.
// No backpressure: en and load are accepted every cycle, and the whole borrow ripple resolves combinationally.
module decade_down_counter #(
  parameter int DIGITS       = 2,
  parameter bit STOP_AT_ZERO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] dec_val;
  logic                dec_wrap;
  logic                load_ok;

  always_comb begin
    dec_val  = count;
    dec_wrap = 1'b1;
    load_ok  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
      // dec_wrap doubles as the borrow travelling up the digit chain
      if (dec_wrap) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          dec_wrap          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      zero     <= 1'b1;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      borrow <= 1'b0;
      if (load_ok) begin
        count    <= load_val;
        zero     <= (load_val == '0);
        load_err <= 1'b0;
      end else begin
        load_err <= 1'b1;
      end
    end else if (en) begin
      load_err <= 1'b0;
      if (dec_wrap && STOP_AT_ZERO) begin
        borrow <= 1'b0;
      end else begin
        count  <= dec_val;
        zero   <= (dec_val == '0);
        borrow <= dec_wrap;
      end
    end else begin
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule
